// File: rtl/w0rm_core_pkg.sv
// Shared W0RM core constants, fetch FSM encoding and small counter helpers.
package w0rm_core_pkg;

    localparam int          ADDR_WIDTH_DEF = 32;
    localparam int          INST_WIDTH_DEF = 32;
    localparam logic [31:0] PC_INCR        = 32'd4;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    // Decrement a 0..2 occupancy counter, holding at zero.
    function automatic logic [1:0] sat_dec2(input logic [1:0] value);
        logic [1:0] result;
        if (value == 2'd0) begin
            result = 2'd0;
        end else begin
            result = value - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/w0rm_fetch_fifo.sv
// Two-entry FIFO with a registered head: entry0 is always the oldest element,
// so the head and valid flag come straight from flops.
module w0rm_fetch_fifo
    import w0rm_core_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [1:0]       count,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0_r;
    logic [WIDTH-1:0] entry1_r;
    logic [WIDTH-1:0] entry0_next_s;
    logic [WIDTH-1:0] entry1_next_s;
    logic [1:0]       count_r;
    logic [1:0]       count_next_s;
    logic             valid_r;
    logic             do_pop_s;

    // Next-state of the entries and occupancy; pops on an empty FIFO are ignored.
    always_comb begin
        do_pop_s      = pop && (count_r != 2'd0);
        entry0_next_s = entry0_r;
        entry1_next_s = entry1_r;
        count_next_s  = count_r;
        if (clear) begin
            count_next_s = 2'd0;
        end else begin
            case ({push, do_pop_s})
                2'b10: begin
                    case (count_r)
                        2'd0: begin
                            entry0_next_s = push_data;
                            count_next_s  = 2'd1;
                        end
                        2'd1: begin
                            entry1_next_s = push_data;
                            count_next_s  = 2'd2;
                        end
                        default: begin
                            count_next_s = count_r;
                        end
                    endcase
                end
                2'b01: begin
                    entry0_next_s = entry1_r;
                    count_next_s  = sat_dec2(count_r);
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_next_s = push_data;
                    end else begin
                        entry0_next_s = entry1_r;
                        entry1_next_s = push_data;
                    end
                end
                default: begin
                    count_next_s = count_r;
                end
            endcase
        end
    end

    // Storage, occupancy and registered valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
            valid_r  <= 1'b0;
        end else begin
            entry0_r <= entry0_next_s;
            entry1_r <= entry1_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != 2'd0);
        end
    end

    assign count = count_r;
    assign valid = valid_r;
    assign head  = entry0_r;

endmodule

// File: rtl/w0rm_fetch_unit.sv
// W0RM instruction fetch stage: owns the PC, issues credit-limited in-order
// word reads, buffers returned words with their PC, and handles redirects by
// flushing the buffer and discarding responses still in flight.
module w0rm_fetch_unit
    import w0rm_core_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    INST_WIDTH = INST_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_req_valid,
    input  logic                  inst_req_ready,
    input  logic                  inst_resp_valid,
    input  logic [INST_WIDTH-1:0] inst_resp_data,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  fetch_valid,
    output logic [INST_WIDTH-1:0] fetch_inst,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  decode_ready
);

    fetch_state_e                     state_r;
    fetch_state_e                     state_next_s;
    logic [ADDR_WIDTH-1:0]            pc_r;
    logic [ADDR_WIDTH-1:0]            pc_next_s;
    logic [ADDR_WIDTH-1:0]            branch_pc_s;
    logic [1:0]                       drop_r;
    logic [1:0]                       drop_next_s;
    logic                             req_valid_s;
    logic                             accept_s;
    logic                             pop_s;
    logic                             resp_s;
    logic [2:0]                       in_use_s;
    logic                             fifo_push_s;
    logic                             fifo_pop_s;
    logic [1:0]                       fifo_count_s;
    logic                             fifo_valid_s;
    logic [ADDR_WIDTH+INST_WIDTH-1:0] fifo_head_s;
    logic [1:0]                       tag_count_s;
    logic                             tag_valid_s;
    logic [ADDR_WIDTH-1:0]            tag_head_s;

    // Handshake qualifiers and the in-flight-plus-buffered credit count;
    // the tag queue occupancy doubles as the outstanding-request counter.
    always_comb begin
        pop_s       = fifo_valid_s && decode_ready;
        resp_s      = inst_resp_valid && tag_valid_s;
        in_use_s    = {1'b0, tag_count_s} + {1'b0, fifo_count_s} - {2'b00, pop_s};
        branch_pc_s = branch_target & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
        accept_s    = req_valid_s && inst_req_ready;
        fifo_push_s = resp_s && !branch_valid && (drop_r == 2'd0);
        fifo_pop_s  = pop_s && !branch_valid;
    end

    // Fetch FSM next state and request strobe: no requests in BOOT or in a redirect cycle.
    always_comb begin
        state_next_s = state_r;
        req_valid_s  = 1'b0;
        case (state_r)
            FETCH_BOOT: begin
                state_next_s = FETCH_RUN;
                req_valid_s  = 1'b0;
            end
            FETCH_RUN: begin
                state_next_s = FETCH_RUN;
                req_valid_s  = !branch_valid && (in_use_s < 3'd2);
            end
            default: begin
                state_next_s = FETCH_BOOT;
                req_valid_s  = 1'b0;
            end
        endcase
    end

    // PC and drop-count next state; a redirect turns every outstanding
    // request (net of a response landing this cycle) into one to discard.
    always_comb begin
        pc_next_s   = pc_r;
        drop_next_s = drop_r;
        if (branch_valid) begin
            pc_next_s   = branch_pc_s;
            drop_next_s = resp_s ? sat_dec2(tag_count_s) : tag_count_s;
        end else begin
            if (accept_s) begin
                pc_next_s = pc_r + ADDR_WIDTH'(PC_INCR);
            end else begin
                pc_next_s = pc_r;
            end
            if (resp_s && (drop_r != 2'd0)) begin
                drop_next_s = sat_dec2(drop_r);
            end else begin
                drop_next_s = drop_r;
            end
        end
    end

    // State, PC and drop-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH_BOOT;
            pc_r    <= RESET_PC;
            drop_r  <= 2'd0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            drop_r  <= drop_next_s;
        end
    end

    w0rm_fetch_fifo #(
        .WIDTH(ADDR_WIDTH)
    ) u_tag_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (accept_s),
        .push_data(pc_r),
        .pop      (resp_s),
        .clear    (1'b0),
        .count    (tag_count_s),
        .valid    (tag_valid_s),
        .head     (tag_head_s)
    );

    w0rm_fetch_fifo #(
        .WIDTH(ADDR_WIDTH + INST_WIDTH)
    ) u_inst_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push_s),
        .push_data({tag_head_s, inst_resp_data}),
        .pop      (fifo_pop_s),
        .clear    (branch_valid),
        .count    (fifo_count_s),
        .valid    (fifo_valid_s),
        .head     (fifo_head_s)
    );

    assign inst_addr      = pc_r;
    assign inst_req_valid = req_valid_s;
    assign fetch_valid    = fifo_valid_s;
    assign fetch_pc       = fifo_head_s[ADDR_WIDTH+INST_WIDTH-1:INST_WIDTH];
    assign fetch_inst     = fifo_head_s[INST_WIDTH-1:0];

endmodule

// File: tb/tb_w0rm_fetch_unit.sv
// Self-checking bench for w0rm_fetch_unit: an in-order memory with random
// latency/backpressure, and a reference model that tracks only the expected
// next request address and the expected next instruction address at decode.
module tb_w0rm_fetch_unit;

    localparam int          AW  = 32;
    localparam int          IW  = 32;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] inst_addr;
    logic          inst_req_valid;
    logic          inst_req_ready = 1'b0;
    logic          inst_resp_valid = 1'b0;
    logic [IW-1:0] inst_resp_data = '0;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          fetch_valid;
    logic [IW-1:0] fetch_inst;
    logic [AW-1:0] fetch_pc;
    logic          decode_ready = 1'b0;

    w0rm_fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_addr      (inst_addr),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_resp_valid(inst_resp_valid),
        .inst_resp_data (inst_resp_data),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .fetch_valid    (fetch_valid),
        .fetch_inst     (fetch_inst),
        .fetch_pc       (fetch_pc),
        .decode_ready   (decode_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory: in-order queue of accepted addresses with earliest response cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;

    // reference model state
    logic [31:0] exp_req;
    logic [31:0] exp_pc;

    // per-cycle samples
    logic        s_rv, s_acc, s_fv, s_resp;
    logic [31:0] s_addr, s_fpc, s_finst;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample, check, update model.
    task automatic step(input bit br, input logic [31:0] tgt, input bit dr, input bit rr, input int lat);
        @(negedge clk);
        cyc++;
        branch_valid   = br;
        branch_target  = tgt;
        decode_ready   = dr;
        inst_req_ready = rr;
        s_resp = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        inst_resp_valid = s_resp;
        inst_resp_data  = s_resp ? mem_data(mq_addr[0]) : 32'h0;
        #1;
        s_rv    = inst_req_valid;
        s_addr  = inst_addr;
        s_fv    = fetch_valid;
        s_fpc   = fetch_pc;
        s_finst = fetch_inst;
        s_acc   = s_rv && rr;
        if (br) check_val("req_in_redirect", s_rv, 0);
        if (prev_hold && !br) begin
            check_val("req_held", s_rv, 1);
            check_val("req_addr_held", s_addr, prev_addr);
        end
        if (s_rv) check_val("req_addr", s_addr, exp_req);
        if (s_fv && dr && !br) begin
            check_val("fetch_pc", s_fpc, exp_pc);
            check_val("fetch_inst", s_finst, mem_data(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (s_resp) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (s_acc) begin
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + lat);
            check_val("in_flight_le2", (mq_addr.size() <= 2), 1);
            exp_req = exp_req + 32'd4;
        end
        if (br) begin
            exp_req = tgt & 32'hFFFF_FFFC;
            exp_pc  = tgt & 32'hFFFF_FFFC;
        end
        prev_hold = s_rv && !rr;
        prev_addr = s_addr;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_req_valid", inst_req_valid, 0);
        check_val("rst_inst_addr", inst_addr, RPC);
        check_val("rst_fetch_valid", fetch_valid, 0);
        check_val("rst_fetch_inst", fetch_inst, 0);
        check_val("rst_fetch_pc", fetch_pc, 0);
        branch_valid    = 1'b0;
        inst_resp_valid = 1'b0;
        inst_resp_data  = '0;
        inst_req_ready  = 1'b0;
        decode_ready    = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        exp_req   = RPC;
        exp_pc    = RPC;
        prev_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("boot_no_req", inst_req_valid, 0);
    endtask

    initial begin
        int acc_step[$];
        int first_fv;
        bit found;

        do_reset();

        // startup stream: 1-cycle memory, always ready
        first_fv = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (s_acc) acc_step.push_back(i);
            if (s_fv && first_fv < 0) begin
                first_fv = i;
                check_val("first_fetch_pc", s_fpc, 32'h100);
            end
        end
        check_val("first_req_cycle", acc_step[0], 0);
        check_val("three_back_to_back", acc_step[2] - acc_step[0], 2);
        check_val("fetch_latency", first_fv - acc_step[0], 2);

        // decode stall: credit must close the request window
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        check_val("stall_req_drops", s_rv, 0);
        check_val("stall_fetch_valid", s_fv, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        // redirect to 0x203 with two requests in flight
        step(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 3);
            if (mq_addr.size() == 2) found = 1'b1;
        end
        check_val("two_in_flight", found, 1);
        step(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (s_acc) begin
                found = 1'b1;
                check_val("redir_first_req", s_addr, 32'h200);
            end
        end
        check_val("redir_req_seen", found, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (s_fv) begin
                found = 1'b1;
                check_val("redir_first_fetch", s_fpc, 32'h200);
            end
        end
        check_val("redir_fetch_seen", found, 1);

        // redirect coinciding with a response and a decode pop
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 32'h0000_3000, 1'b1, 1'b1, 1);
        check_val("redir_resp_and_pop", s_resp && s_fv, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        check_val("redir_fifo_empty", s_fv, 0);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (s_acc) found = 1'b1;
        end
        check_val("wrap_req_seen", found, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        check_val("pc_wrap", s_addr, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        // reset mid-operation with work buffered and in flight
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 2);
        step(1'b0, 32'h0, 1'b0, 1'b1, 2);
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (s_acc) begin
                found = 1'b1;
                check_val("resume_req", s_addr, RPC);
            end
        end
        check_val("resume_seen", found, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
